// File: rtl/approx_mult_sched_if.sv
`default_nettype none
// ============================================================================
// approx_mult_sched_if : requester/response handshake bundle for approx_mult_sched
// Revision 1.0
// ============================================================================
interface approx_mult_sched_if #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [8*NREQ-1:0] req_a;
   logic [8*NREQ-1:0] req_b;
   logic              resp_valid;
   logic              resp_ready;
   logic [16:0]       resp_x;
   logic [IDW-1:0]    resp_id;

   modport master (
      output req_valid, req_a, req_b, resp_ready,
      input  req_ready, resp_valid, resp_x, resp_id
   );

   modport slave (
      input  req_valid, req_a, req_b, resp_ready,
      output req_ready, resp_valid, resp_x, resp_id
   );
endinterface
`default_nettype wire

// File: rtl/approx_mult_sched.sv
`default_nettype none
// ============================================================================
// approx_mult_sched : round-robin sharing of one external 8x8 approximate
// multiplier; optional error monitor enabled by APPROX_ERR_MON_EN.
// Revision 1.0
// ============================================================================
module approx_mult_sched #(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 1,
   parameter int IDW     = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   approx_mult_sched_if.slave bus,
   output logic [7:0]         mul_a,
   output logic [7:0]         mul_b,
   input  wire logic [16:0]   mul_x,
   output logic               busy
`ifdef APPROX_ERR_MON_EN
   ,
   output logic [16:0]        resp_err,
   output logic [16:0]        err_max
`endif
);

   localparam int CW = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [IDW-1:0] r_ptr;
   logic [CW-1:0]  r_cnt;
   logic [7:0]     r_mul_a;
   logic [7:0]     r_mul_b;
   logic [16:0]    r_resp_x;
   logic [IDW-1:0] r_resp_id;
   logic           r_resp_valid;

   logic           w_found;
   logic           w_accept;
   logic [IDW-1:0] w_gnt;
   logic [IDW-1:0] w_idx;
   logic [IDW:0]   w_sum;
   logic [IDW-1:0] w_ptr_nxt;
   logic [7:0]     w_opa;
   logic [7:0]     w_opb;

   // Search from r_ptr upward, wrapping modulo NREQ; the first valid requester wins.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = '0;
      w_sum   = '0;
      w_opa   = '0;
      w_opb   = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
         if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
         end
         w_idx = w_sum[IDW-1:0];
         if (!w_found && bus.req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = w_idx;
            w_opa   = bus.req_a[{w_idx, 3'b000} +: 8];
            w_opb   = bus.req_b[{w_idx, 3'b000} +: 8];
         end
      end
   end

   assign w_accept  = (r_state == ST_IDLE) && w_found;
   assign w_ptr_nxt = (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_found) w_state_nxt = ST_ISSUE;
         ST_ISSUE: w_state_nxt = ST_WAIT;
         ST_WAIT:  if (r_cnt == '0) w_state_nxt = ST_RESP;
         ST_RESP:  if (bus.resp_ready) w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr        <= '0;
         r_cnt        <= '0;
         r_mul_a      <= '0;
         r_mul_b      <= '0;
         r_resp_x     <= '0;
         r_resp_id    <= '0;
         r_resp_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_mul_a   <= w_opa;
                  r_mul_b   <= w_opb;
                  r_resp_id <= w_gnt;
                  r_ptr     <= w_ptr_nxt;
                  r_cnt     <= CW'(MUL_LAT-1);
               end
            end
            ST_WAIT: begin
               if (r_cnt == '0) begin
                  r_resp_x     <= mul_x;
                  r_resp_valid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (bus.resp_ready) r_resp_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

`ifdef APPROX_ERR_MON_EN
   logic [15:0] w_prod;
   logic [16:0] w_exact;
   logic [16:0] w_abs_err;
   logic [16:0] r_resp_err;
   logic [16:0] r_err_max;

   assign w_prod    = 16'(r_mul_a) * 16'(r_mul_b);
   assign w_exact   = {1'b0, w_prod};
   assign w_abs_err = (w_exact >= mul_x) ? (w_exact - mul_x) : (mul_x - w_exact);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_resp_err <= '0;
         r_err_max  <= '0;
      end else begin
         if (r_state == ST_WAIT && r_cnt == '0) r_resp_err <= w_abs_err;
         if (r_state == ST_RESP && bus.resp_ready && r_resp_err > r_err_max) begin
            r_err_max <= r_resp_err;
         end
      end
   end

   assign resp_err = r_resp_err;
   assign err_max  = r_err_max;
`endif

   // The accept pulse is masked during reset so no requester sees a lost handshake.
   assign bus.req_ready  = (w_accept && !rst) ? (NREQ'(1) << w_gnt) : '0;
   assign bus.resp_valid = r_resp_valid;
   assign bus.resp_x     = r_resp_x;
   assign bus.resp_id    = r_resp_id;
   assign mul_a          = r_mul_a;
   assign mul_b          = r_mul_b;
   assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire
